mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory-access/writeback stage fed by the execute-stage ALU outputs (op, wreg, wren, result, address).
//  Runs loads/stores against word-addressed data memory over a req/ack handshake, stalling execute while busy.
//  Returns registered register-file write-back (reg, data, enable); non-memory ops pass through in one cycle.
// PARAMETERS
//  TIMEOUT   256  max cycles waiting for dmem_ack before aborting the access (8-bit counter, >=2)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  ex_valid    in   1   execute-stage outputs valid this cycle
//  ex_op       in   6   opcode (0 R-type, 1/3/4/5/6 imm ALU, 16 lw, 18 lh, 20 lb, 24 sw, 26 sh, 28 sb, 41 jal)
//  ex_wreg     in   5   destination register
//  ex_wren     in   4   store byte-write mask, active-low (0000 sw, 1100 sh, 1110 sb, 1111 none)
//  ex_result   in   32  ALU result; store data for stores
//  ex_addr     in   32  word address for loads/stores
//  ex_stall    out  1   1 = stage busy, execute must hold its outputs
//  dmem_req    out  1   memory request, held until ack
//  dmem_wen    out  4   active-low byte write mask (1111 = read)
//  dmem_addr   out  32  word address
//  dmem_wdata  out  32  store data
//  dmem_ack    in   1   one-cycle completion; dmem_rdata valid same cycle
//  dmem_rdata  in   32  load data
//  wb_we       out  1   register-file write enable, one-cycle pulse
//  wb_reg      out  5   write-back register
//  wb_data     out  32  write-back data
//  mem_err     out  1   sticky: an access timed out; cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE; dmem_req=0, dmem_wen=1111, dmem_addr/wdata=0, wb_we=0, wb_reg=0, wb_data=0,
//   ex_stall=0, mem_err=0, timeout counter=0.
//  FSM IDLE -> ACCESS -> IDLE.
//  IDLE, ex_valid=0: wb_we=0 next cycle.
//  IDLE, ex_valid, non-memory op: next cycle wb_we=1 only for ops 0,1,3,4,5,6,41 with ex_wreg!=0;
//   wb_reg=ex_wreg, wb_data=ex_result. Unknown ops: wb_we=0. Latency 1; no stall.
//  IDLE, ex_valid, op in {16,18,20,24,26,28}: register ex_addr, ex_result, mask (loads 1111, stores ex_wren),
//   op and wreg. Assert dmem_req next cycle and enter ACCESS.
//  ex_stall is combinational: 1 in ACCESS, and 1 in IDLE while ex_valid carries a memory op.
//  ACCESS: hold dmem_req, wen, addr and wdata stable. On dmem_ack: drop req next cycle and return to IDLE.
//   Same edge: loads set wb_we=(wreg!=0), wb_data = lw rdata, lh sext(rdata[15:0]), lb sext(rdata[7:0]).
//   Stores set wb_we=0.
//  Load-to-writeback latency = ack cycle + 1. Back-to-back: a new ex_valid op is accepted the cycle after ack.
//  Timeout: counter clears on entering ACCESS and increments each ACCESS cycle without ack.
//   At TIMEOUT-1 without ack: drop req, set mem_err, wb_we=0, return to IDLE (op discarded).
//   Ack on that same cycle wins over the timeout.
//  dmem_ack while IDLE is ignored. ex_wren is ignored for non-store ops.
//  rst mid-access: immediate return to reset values; the outstanding request is abandoned.
//  Widths: all data 32-bit; sign extension replicates bit 15 or bit 7; counter saturates at TIMEOUT-1.
// STRUCTURE
//  Shared package (cpu_defs): opcode constants (OP_RTYPE, OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI,
//   OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB, OP_JAL), WREN_SW/SH/SB/NONE masks, FSM state encoding.
//  One sub-module: load_extend (op + rdata -> wb_data), combinational, reusable by the forwarding unit.
// TESTING
//  1 op=0, wreg=5, result=0x12345678, valid 1 cycle -> next cycle wb_we=1, wb_reg=5, wb_data=0x12345678, stall=0.
//  2 op=16, addr=0x40, wreg=3; ack after 3 cycles with rdata=0xDEADBEEF -> req held 3 cycles, addr=0x40,
//    wen=1111; cycle after ack wb_we=1, wb_reg=3, wb_data=0xDEADBEEF.
//  3 op=20 (lb) rdata=0x00000080 -> wb_data=0xFFFFFF80; op=18 (lh) rdata=0x00017FFF -> wb_data=0x00007FFF.
//  4 op=26 (sh), wren=1100, result=0xAAAA5555, addr=7 -> dmem_wen=1100, wdata=0xAAAA5555, addr=7;
//    wb_we stays 0 across the access.
//  5 TIMEOUT=4, op=24 and no ack -> req high 4 cycles, then req=0, mem_err=1, stall=0; next op=1 completes normally.
//  6 rst asserted in ACCESS -> same-cycle req=0, stall=0, wb_we=0; after release, op=41 wreg=31 result=0x11
//    -> wb_we=1, wb_reg=31, wb_data=0x11.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, store byte masks, memory-stage state encoding and op classifiers.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_LUI   = 6'd3;
    localparam logic [5:0] OP_ANDI  = 6'd4;
    localparam logic [5:0] OP_ORI   = 6'd5;
    localparam logic [5:0] OP_XORI  = 6'd6;
    localparam logic [5:0] OP_LW    = 6'd16;
    localparam logic [5:0] OP_LH    = 6'd18;
    localparam logic [5:0] OP_LB    = 6'd20;
    localparam logic [5:0] OP_SW    = 6'd24;
    localparam logic [5:0] OP_SH    = 6'd26;
    localparam logic [5:0] OP_SB    = 6'd28;
    localparam logic [5:0] OP_JAL   = 6'd41;

    // Active-low byte write masks; all ones means a read.
    localparam logic [3:0] WREN_SW   = 4'b0000;
    localparam logic [3:0] WREN_SH   = 4'b1100;
    localparam logic [3:0] WREN_SB   = 4'b1110;
    localparam logic [3:0] WREN_NONE = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LW, OP_LH, OP_LB: is_load = 1'b1;
            default:             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SW, OP_SH, OP_SB: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        is_mem = is_load(op) || is_store(op);
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI, OP_JAL: writes_reg = 1'b1;
            default:                                                   writes_reg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment: sign-extends halfword/byte loads, passes words through.
module load_extend
    import cpu_defs::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    // Select the extension rule from the load opcode
    always_comb begin
        data = rdata;
        case (op)
            OP_LH:   data = {{16{rdata[15]}}, rdata[15:0]};
            OP_LB:   data = {{24{rdata[7]}}, rdata[7:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: runs loads and stores over a req/ack data-memory handshake
// with a bounded wait, and produces registered register-file writeback.
module mem_wb_stage
    import cpu_defs::*;
#(
    parameter int unsigned TIMEOUT = 32'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [5:0]  ex_op,
    input  logic [4:0]  ex_wreg,
    input  logic [3:0]  ex_wren,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_addr,
    output logic        ex_stall,
    output logic        dmem_req,
    output logic [3:0]  dmem_wen,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    mem_state_t  state_r;
    logic [5:0]  op_r;
    logic [4:0]  wreg_r;
    logic [7:0]  cnt_r;
    logic [31:0] ld_data_s;

    load_extend u_load_extend (
        .op    (op_r),
        .rdata (dmem_rdata),
        .data  (ld_data_s)
    );

    // Execute must hold while an access is outstanding or one is being presented
    assign ex_stall = (state_r == ST_ACCESS) || (ex_valid && is_mem(ex_op));

    // Stage FSM, memory request registers and writeback registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            op_r       <= 6'd0;
            wreg_r     <= 5'd0;
            cnt_r      <= 8'd0;
            dmem_req   <= 1'b0;
            dmem_wen   <= WREN_NONE;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            wb_we      <= 1'b0;
            wb_reg     <= 5'd0;
            wb_data    <= 32'd0;
            mem_err    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid && is_mem(ex_op)) begin
                        op_r       <= ex_op;
                        wreg_r     <= ex_wreg;
                        dmem_addr  <= ex_addr;
                        dmem_wdata <= ex_result;
                        dmem_wen   <= is_store(ex_op) ? ex_wren : WREN_NONE;
                        dmem_req   <= 1'b1;
                        cnt_r      <= 8'd0;
                        wb_we      <= 1'b0;
                        state_r    <= ST_ACCESS;
                    end else if (ex_valid) begin
                        wb_we   <= writes_reg(ex_op) && (ex_wreg != 5'd0);
                        wb_reg  <= ex_wreg;
                        wb_data <= ex_result;
                    end else begin
                        wb_we <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    // An ack on the final allowed cycle still completes the access
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        wb_we    <= is_load(op_r) && (wreg_r != 5'd0);
                        wb_reg   <= wreg_r;
                        wb_data  <= ld_data_s;
                        state_r  <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        dmem_req <= 1'b0;
                        mem_err  <= 1'b1;
                        wb_we    <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                        wb_we <= 1'b0;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                    wb_we    <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
